// File: rtl/spi_req_arbiter.sv
// Shares one SPI master between NREQ requesters and times each 8-bit transfer locally.
// Define SPI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
//
// state  | meaning
// IDLE   | arbitrate pending requests, capture winner byte/slave select
// LOAD   | one cycle: strobe master, grant winner
// XFER   | 8*CLKDIV+2 cycles while the master shifts; Done on last cycle
// GAP    | GAP idle cycles before the next arbitration
module spi_req_arbiter #(
  parameter int NREQ   = 4,
  parameter int CLKDIV = 4,
  parameter int GAP    = 2
) (
  input  logic              Clk_i,
  input  logic              Rst_ni,
  input  logic [NREQ-1:0]   Req_i,
  input  logic [8*NREQ-1:0] Data_i,
  input  logic [2*NREQ-1:0] Ss_i,
  output logic [NREQ-1:0]   Gnt_o,
  output logic [NREQ-1:0]   Done_o,
  output logic              Busy_o,
  output logic [7:0]        Buf_o,
  output logic [1:0]        Ss_o,
  output logic              Strobe_o
);

  localparam int XFER_CYC = 8 * CLKDIV + 2;
  localparam int CW       = $clog2(XFER_CYC + GAP + 1);
  localparam int PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GAP_LD   = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_XFER,
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   sel_q, sel_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic              strobe_q, strobe_d;
  logic [7:0]        buf_q, buf_d;
  logic [1:0]        ss_q, ss_d;

  logic              win_vld;
  logic [PW-1:0]     win_idx;
  logic [NREQ-1:0]   win_oh;
  logic [7:0]        win_data;
  logic [1:0]        win_ss;

`ifndef SPI_ARB_FIXED_PRIO_EN
  logic [PW-1:0]     ptr_q, ptr_d;
`endif

  // Scan downwards so the last hit, i.e. the highest-priority candidate, wins.
  always_comb begin
    int j;
    win_vld  = 1'b0;
    win_idx  = '0;
    win_data = '0;
    win_ss   = '0;
    j        = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
      j = i;
`else
      j = (int'(ptr_q) + i) % NREQ;
`endif
      if (Req_i[j]) begin
        win_vld  = 1'b1;
        win_idx  = PW'(j);
        win_data = Data_i[8*j +: 8];
        win_ss   = Ss_i[2*j +: 2];
      end
    end
    win_oh = NREQ'(1) << win_idx;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    buf_d    = buf_q;
    ss_d     = ss_q;
    gnt_d    = '0;
    done_d   = '0;
    strobe_d = 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d  = S_LOAD;
          sel_d    = win_oh;
          gnt_d    = win_oh;
          strobe_d = 1'b1;
          buf_d    = win_data;
          ss_d     = win_ss;
`ifndef SPI_ARB_FIXED_PRIO_EN
          ptr_d    = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
`endif
        end
      end
      S_LOAD: begin
        state_d = S_XFER;
        cnt_d   = CW'(XFER_CYC - 1);
      end
      S_XFER: begin
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            cnt_d   = CW'(GAP_LD);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          // Registered Done lands in the final XFER cycle (count reaches zero).
          if (cnt_q == CW'(1)) done_d = sel_q;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      buf_q    <= '0;
      ss_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      buf_q    <= buf_d;
      ss_q     <= ss_d;
    end
  end

`ifndef SPI_ARB_FIXED_PRIO_EN
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`endif

  assign Gnt_o    = gnt_q;
  assign Done_o   = done_q;
  assign Busy_o   = busy_q;
  assign Buf_o    = buf_q;
  assign Ss_o     = ss_q;
  assign Strobe_o = strobe_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: a GAP=2 instance plus a GAP=0 instance for spacing.
module tb_spi_req_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [7:0]  ss;

  logic [3:0] gnt_a, done_a, gnt_b, done_b;
  logic       busy_a, strobe_a, busy_b, strobe_b;
  logic [7:0] buf_a, buf_b;
  logic [1:0] ss_a, ss_b;

  int checks = 0;
  int errors = 0;

  spi_req_arbiter #(.NREQ(4), .CLKDIV(4), .GAP(2)) dut_a (
    .Clk_i(clk), .Rst_ni(rst_n), .Req_i(req), .Data_i(data), .Ss_i(ss),
    .Gnt_o(gnt_a), .Done_o(done_a), .Busy_o(busy_a), .Buf_o(buf_a),
    .Ss_o(ss_a), .Strobe_o(strobe_a)
  );

  spi_req_arbiter #(.NREQ(4), .CLKDIV(4), .GAP(0)) dut_b (
    .Clk_i(clk), .Rst_ni(rst_n), .Req_i(req), .Data_i(data), .Ss_i(ss),
    .Gnt_o(gnt_b), .Done_o(done_b), .Busy_o(busy_b), .Buf_o(buf_b),
    .Ss_o(ss_b), .Strobe_o(strobe_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_gnt(input int budget, output logic [3:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gnt_a !== 4'b0) begin
        g  = gnt_a;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit bad;
    bad = 1'b0;
    data = '0;
    ss   = '0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({gnt_a, done_a, busy_a, buf_a, ss_a, strobe_a} !== 20'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_idle: outputs nonzero during 100 idle cycles, required all 0");
    end
  endtask

  task automatic test_single();
    bit early, spur;
    data = 32'h0000_A500;
    ss   = 8'b0000_1000;
    req  = 4'b0010;
    @(negedge clk);
    checks++;
    if ({strobe_a, gnt_a, busy_a, buf_a, ss_a} !== {1'b1, 4'b0010, 1'b1, 8'hA5, 2'd2}) begin
      errors++;
      $display("FAIL load_outputs: got strobe=%0b gnt=%b busy=%0b buf=%h ss=%0d, required 1 0010 1 a5 2",
               strobe_a, gnt_a, busy_a, buf_a, ss_a);
    end
    req   = '0;
    early = 1'b0;
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      if (k == 1) data = 32'h0;
      if (k == 5) req = 4'b0100;
      if (k == 6) req = 4'b0000;
      if (k < 34 && done_a !== 4'b0) early = 1'b1;
      if (k == 20) begin
        checks++;
        if (buf_a !== 8'hA5 || strobe_a !== 1'b0 || busy_a !== 1'b1) begin
          errors++;
          $display("FAIL xfer_hold: got buf=%h strobe=%0b busy=%0b, required a5 0 1", buf_a, strobe_a, busy_a);
        end
      end
      if (k == 34) begin
        checks++;
        if (done_a !== 4'b0010 || early) begin
          errors++;
          $display("FAIL done_timing: got done=%b early=%0b at strobe+34, required 0010 0", done_a, early);
        end
      end
      if (k == 35) begin
        checks++;
        if (done_a !== 4'b0 || busy_a !== 1'b1) begin
          errors++;
          $display("FAIL gap_state: got done=%b busy=%0b, required 0000 1", done_a, busy_a);
        end
      end
      if (k == 37) begin
        checks++;
        if (busy_a !== 1'b0 || buf_a !== 8'hA5 || ss_a !== 2'd2) begin
          errors++;
          $display("FAIL idle_hold: got busy=%0b buf=%h ss=%0d, required 0 a5 2", busy_a, buf_a, ss_a);
        end
      end
    end
    spur = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (strobe_a !== 1'b0 || gnt_a !== 4'b0) spur = 1'b1;
    end
    checks++;
    if (spur) begin
      errors++;
      $display("FAIL ignored_req: strobe/gnt seen for request raised outside IDLE, required none");
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] exp [5];
    logic [3:0] g;
    bit ok;
`ifdef SPI_ARB_FIXED_PRIO_EN
    exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    data = 32'h4433_2211;
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_gnt(100, g, ok);
      checks++;
      if (!ok || g !== exp[n]) begin
        errors++;
        $display("FAIL grant_order[%0d]: got gnt=%b timeout=%0b, required %b", n, g, !ok, exp[n]);
      end
    end
    req = '0;
    repeat (60) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t1a, t2a, t1b, t2b;
    t1a = -1; t2a = -1; t1b = -1; t2b = -1;
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (strobe_a === 1'b1) begin
        if (t1a < 0) t1a = c;
        else if (t2a < 0) t2a = c;
      end
      if (strobe_b === 1'b1) begin
        if (t1b < 0) t1b = c;
        else if (t2b < 0) t2b = c;
      end
    end
    req = '0;
    checks++;
    if (t1a < 0 || t2a < 0 || t2a - t1a != 38) begin
      errors++;
      $display("FAIL spacing_gap2: got %0d cycles, required 38", t2a - t1a);
    end
    checks++;
    if (t1b < 0 || t2b < 0 || t2b - t1b != 36) begin
      errors++;
      $display("FAIL spacing_gap0: got %0d cycles, required 36", t2b - t1b);
    end
    repeat (60) @(negedge clk);
  endtask

  task automatic test_reset_mid_xfer();
    logic [3:0] g;
    bit ok, spur;
    data = 32'h4433_2211;
    ss   = 8'b1110_0101;
    do_reset();
    req = 4'b0001;
    wait_gnt(10, g, ok);
    checks++;
    if (!ok || g !== 4'b0001) begin
      errors++;
      $display("FAIL pre_abort_grant: got gnt=%b timeout=%0b, required 0001", g, !ok);
    end
    req = '0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt_a, done_a, busy_a, buf_a, ss_a, strobe_a} !== 20'b0) begin
      errors++;
      $display("FAIL async_abort: got gnt=%b done=%b busy=%0b buf=%h ss=%0d strobe=%0b, required all 0",
               gnt_a, done_a, busy_a, buf_a, ss_a, strobe_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spur = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a !== 4'b0 || busy_a !== 1'b0) spur = 1'b1;
    end
    checks++;
    if (spur) begin
      errors++;
      $display("FAIL no_done_after_abort: done or busy seen after reset, required none");
    end
    req = 4'b0011;
    wait_gnt(10, g, ok);
    req = '0;
    checks++;
    if (!ok || g !== 4'b0001 || buf_a !== 8'h11 || ss_a !== 2'd1) begin
      errors++;
      $display("FAIL post_abort_grant: got gnt=%b buf=%h ss=%0d timeout=%0b, required 0001 11 1",
               g, buf_a, ss_a, !ok);
    end
    repeat (60) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    data  = '0;
    ss    = '0;
    test_reset();
    test_single();
    test_arbitration();
    test_back_to_back();
    test_reset_mid_xfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
